// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory port arbiter:
// byte-enable shapes, port indices and the response record.
package dm_pkg;

    localparam logic [3:0] BE_BYTE    = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    typedef struct packed {
        logic valid;
        logic port;
        logic err;
        logic we;
    } dm_rsp_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } dm_state_e;

endpackage

// File: rtl/dm_port_arbiter_if.sv
// Two requester ports (CPU = p0, DMA/debug = p1) of the data-memory arbiter.
// master: requester side; slave: arbiter side.
interface dm_port_arbiter_if;

    logic        p0_req;
    logic        p0_we;
    logic [31:0] p0_addr;
    logic [3:0]  p0_be;
    logic [31:0] p0_wdata;
    logic        p0_gnt;
    logic        p0_rvalid;
    logic        p0_err;
    logic [31:0] p0_rdata;

    logic        p1_req;
    logic        p1_we;
    logic [31:0] p1_addr;
    logic [3:0]  p1_be;
    logic [31:0] p1_wdata;
    logic        p1_gnt;
    logic        p1_rvalid;
    logic        p1_err;
    logic [31:0] p1_rdata;

    modport master (
        output p0_req, p0_we, p0_addr, p0_be, p0_wdata,
        input  p0_gnt, p0_rvalid, p0_err, p0_rdata,
        output p1_req, p1_we, p1_addr, p1_be, p1_wdata,
        input  p1_gnt, p1_rvalid, p1_err, p1_rdata
    );

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_be, p0_wdata,
        output p0_gnt, p0_rvalid, p0_err, p0_rdata,
        input  p1_req, p1_we, p1_addr, p1_be, p1_wdata,
        output p1_gnt, p1_rvalid, p1_err, p1_rdata
    );

endinterface

// File: rtl/dm_be_check.sv
// Byte-enable shape / alignment check (combinational).
// Ports: addr[1:0], be in; legal out (1 = shape and alignment ok).
module dm_be_check
    import dm_pkg::*;
(
    input  logic [1:0] addr,
    input  logic [3:0] be,
    output logic       legal
);

    always_comb begin
        legal = 1'b0;
        unique case (be)
            BE_BYTE:      legal = (addr == 2'd0);
            BE_BYTE << 1: legal = (addr == 2'd1);
            BE_BYTE << 2: legal = (addr == 2'd2);
            BE_BYTE << 3: legal = (addr == 2'd3);
            BE_HALF_LO:   legal = (addr == 2'd0);
            BE_HALF_HI:   legal = (addr == 2'd2);
            BE_WORD:      legal = (addr == 2'd0);
            default:      legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the data memory between CPU (p0) and DMA/debug (p1) ports.
// Ports: clk, reset (sync, active-high), bus (slave), mem_* command,
// mem_rdata, busy. Define DM_ARB_RR_EN for round-robin arbitration.
module dm_port_arbiter
    import dm_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic               clk,
    input  logic               reset,
    dm_port_arbiter_if.slave   bus,
    output logic               mem_en,
    output logic               mem_we,
    output logic [31:0]        mem_addr,
    output logic [3:0]         mem_be,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_rdata,
    output logic               busy
);

    logic        legal0, legal1;
    logic        win1, gnt0, gnt1;
    logic        sel_legal, sel_we;
    logic [31:0] sel_addr, sel_wdata;
    logic [3:0]  sel_be;
    dm_rsp_t     rsp_q, rsp_d;
    dm_state_e   state_q, state_d;
    logic        rsp_live, rd_ok;

    dm_be_check u_chk0 (
        .addr  (bus.p0_addr[1:0]),
        .be    (bus.p0_be),
        .legal (legal0)
    );

    dm_be_check u_chk1 (
        .addr  (bus.p1_addr[1:0]),
        .be    (bus.p1_be),
        .legal (legal1)
    );

`ifdef DM_ARB_RR_EN
    logic last_q, last_d;

    // On a tie the port not granted last time wins.
    assign win1 = !bus.p0_req || (last_q == PORT_CPU);

    always_comb begin
        last_d = last_q;
        if (gnt1)      last_d = PORT_DMA;
        else if (gnt0) last_d = PORT_CPU;
    end

    always_ff @(posedge clk) begin
        if (reset) last_q <= PORT_DMA;
        else       last_q <= last_d;
    end
`else
    logic [7:0] starve_q, starve_d;

    assign win1 = !bus.p0_req ||
                  (32'(starve_q) >= STARVE_LIMIT);

    always_comb begin
        starve_d = starve_q;
        if (!bus.p1_req || gnt1)    starve_d = '0;
        else if (starve_q != 8'hFF) starve_d = starve_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) starve_q <= '0;
        else       starve_q <= starve_d;
    end
`endif

    assign gnt1 = !reset && bus.p1_req && win1;
    assign gnt0 = !reset && bus.p0_req && !gnt1;
    assign bus.p0_gnt = gnt0;
    assign bus.p1_gnt = gnt1;

    always_comb begin
        sel_legal = 1'b0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_be    = '0;
        sel_wdata = '0;
        unique case (1'b1)
            gnt0: begin
                sel_legal = legal0;
                sel_we    = bus.p0_we;
                sel_addr  = bus.p0_addr;
                sel_be    = bus.p0_be;
                sel_wdata = bus.p0_wdata;
            end
            gnt1: begin
                sel_legal = legal1;
                sel_we    = bus.p1_we;
                sel_addr  = bus.p1_addr;
                sel_be    = bus.p1_be;
                sel_wdata = bus.p1_wdata;
            end
            default: ;
        endcase
    end

    // Illegal grants never reach memory; they only produce an err response.
    assign mem_en    = (gnt0 || gnt1) && sel_legal;
    assign mem_we    = mem_en && sel_we;
    assign mem_addr  = mem_en ? {sel_addr[31:2], 2'b00} : '0;
    assign mem_be    = mem_en ? sel_be : '0;
    assign mem_wdata = mem_en ? sel_wdata : '0;

    always_comb begin
        rsp_d       = '0;
        rsp_d.valid = gnt0 || gnt1;
        rsp_d.port  = gnt1;
        rsp_d.err   = rsp_d.valid && !sel_legal;
        rsp_d.we    = sel_we;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (rsp_d.valid)  state_d = ST_RESP;
            ST_RESP: if (!rsp_d.valid) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            rsp_q   <= rsp_d;
        end
    end

    // Outputs are held quiet while reset is asserted, so a response
    // captured just before reset is never seen.
    assign rsp_live = (state_q == ST_RESP) && rsp_q.valid && !reset;
    assign rd_ok    = rsp_live && !rsp_q.err && !rsp_q.we;
    assign busy     = rsp_live;

    assign bus.p0_rvalid = rsp_live && (rsp_q.port == PORT_CPU);
    assign bus.p1_rvalid = rsp_live && (rsp_q.port == PORT_DMA);
    assign bus.p0_err    = bus.p0_rvalid && rsp_q.err;
    assign bus.p1_err    = bus.p1_rvalid && rsp_q.err;
    assign bus.p0_rdata  = (bus.p0_rvalid && rd_ok) ? mem_rdata : '0;
    assign bus.p1_rdata  = (bus.p1_rvalid && rd_ok) ? mem_rdata : '0;

endmodule
